// File: rtl/clock_mode_ctrl.sv
// Alarm-clock mode sequencer: routes button presses to the time/alarm adjust
// blocks, gates the running counter, drives display blink and the alarm ring.
module clock_mode_ctrl #(
    parameter int unsigned RING_SECS = 60,
    parameter int unsigned IDLE_SECS = 30,
    parameter int unsigned CNT_W     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       bt_c,
    input  logic       bt_l,
    input  logic       bt_r,
    input  logic       bt_u,
    input  logic       bt_d,
    input  logic       alarm_match,
    output logic       en_time_hr,
    output logic       en_time_min,
    output logic       en_alarm_hr,
    output logic       en_alarm_min,
    output logic       load_time,
    output logic       clk_run,
    output logic       disp_alarm,
    output logic [3:0] blank,
    output logic       alarm_armed,
    output logic       buzzer
);

    localparam logic [1:0] S_CLOCK     = 2'd0;
    localparam logic [1:0] S_SET_TIME  = 2'd1;
    localparam logic [1:0] S_SET_ALARM = 2'd2;
    localparam logic [1:0] S_RINGING   = 2'd3;

    localparam logic F_MIN  = 1'b0;
    localparam logic F_HOUR = 1'b1;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_SECS - 1);
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);

    logic [1:0]       state, state_nx;
    logic             field, field_nx;
    logic             armed_nx;
    logic             load_nx;
    logic             ring_done;
    logic             blink_phase;
    logic [CNT_W-1:0] idle_cnt, ring_cnt;
    logic             any_bt;
    logic             in_set;

    assign any_bt = bt_c | bt_l | bt_r | bt_u | bt_d;
    assign in_set = (state == S_SET_TIME) || (state == S_SET_ALARM);

    always_comb begin
        state_nx = state;
        field_nx = field;
        armed_nx = alarm_armed;
        load_nx  = 1'b0;
        case (state)
            S_CLOCK: begin
                if (bt_c) begin
                    state_nx = S_SET_TIME;
                    field_nx = F_MIN;
                end else if (alarm_match && alarm_armed && !ring_done) begin
                    state_nx = S_RINGING;
                end else if (!bt_l && !bt_r && (bt_u || bt_d)) begin
                    armed_nx = ~alarm_armed;
                end
            end
            S_SET_TIME, S_SET_ALARM: begin
                if (bt_c) begin
                    state_nx = (state == S_SET_TIME) ? S_SET_ALARM : S_CLOCK;
                    field_nx = F_MIN;
                    load_nx  = (state == S_SET_TIME);
                end else if (bt_l) begin
                    field_nx = F_HOUR;
                end else if (bt_r) begin
                    field_nx = F_MIN;
                end else if (!any_bt && tick_1hz && idle_cnt >= IDLE_LAST) begin
                    // timeout abandons the edit: no load strobe
                    state_nx = S_CLOCK;
                    field_nx = F_MIN;
                end
            end
            S_RINGING: begin
                if (any_bt || (tick_1hz && ring_cnt >= RING_LAST)) begin
                    state_nx = S_CLOCK;
                    field_nx = F_MIN;
                end
            end
            default: begin
                state_nx = S_CLOCK;
                field_nx = F_MIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_CLOCK;
            field       <= F_MIN;
            alarm_armed <= 1'b0;
            load_time   <= 1'b0;
            blink_phase <= 1'b0;
            ring_done   <= 1'b0;
            idle_cnt    <= '0;
            ring_cnt    <= '0;
        end else begin
            state       <= state_nx;
            field       <= field_nx;
            alarm_armed <= armed_nx;
            load_time   <= load_nx;
            if (tick_1hz)
                blink_phase <= ~blink_phase;

            // ring_done blocks re-triggering until alarm_match has dropped
            if (state == S_RINGING && state_nx != S_RINGING)
                ring_done <= 1'b1;
            else if (!alarm_match)
                ring_done <= 1'b0;

            if (state_nx != state) begin
                idle_cnt <= '0;
                ring_cnt <= '0;
            end else begin
                if (in_set) begin
                    if (any_bt)
                        idle_cnt <= '0;
                    else if (tick_1hz && idle_cnt != '1)
                        idle_cnt <= idle_cnt + 1'b1;
                end
                if (state == S_RINGING && tick_1hz && ring_cnt != '1)
                    ring_cnt <= ring_cnt + 1'b1;
            end
        end
    end

    assign en_time_min  = (state == S_SET_TIME)  && (field == F_MIN);
    assign en_time_hr   = (state == S_SET_TIME)  && (field == F_HOUR);
    assign en_alarm_min = (state == S_SET_ALARM) && (field == F_MIN);
    assign en_alarm_hr  = (state == S_SET_ALARM) && (field == F_HOUR);
    assign clk_run      = (state != S_SET_TIME);
    assign disp_alarm   = (state == S_SET_ALARM);
    assign buzzer       = (state == S_RINGING);

    always_comb begin
        blank = 4'b0000;
        if (in_set && blink_phase)
            blank = (field == F_HOUR) ? 4'b1100 : 4'b0011;
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: vector table plus hand-written timeout, ring and
// reset sequences, all checked through an expected-output queue.
module tb_clock_mode_ctrl;

    typedef struct packed {
        logic c, l, r, u, d, tick, match;
    } in_t;

    typedef struct packed {
        logic [3:0] en;     // {time_hr, time_min, alarm_hr, alarm_min}
        logic       load, run, disp;
        logic [3:0] blank;
        logic       armed, buzz;
    } out_t;

    typedef struct {
        in_t        i;
        logic [3:0] en;
        logic       load, run, disp, armed, buzz;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, tick_1hz, bt_c, bt_l, bt_r, bt_u, bt_d, alarm_match;
    logic       en_time_hr, en_time_min, en_alarm_hr, en_alarm_min;
    logic       load_time, clk_run, disp_alarm, alarm_armed, buzzer;
    logic [3:0] blank;

    out_t exp_q[$];
    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    logic phase    = 1'b0;

    localparam in_t NONE  = 7'b0000000;
    localparam in_t C     = 7'b1000000;
    localparam in_t L     = 7'b0100000;
    localparam in_t R     = 7'b0010000;
    localparam in_t U     = 7'b0001000;
    localparam in_t TICK  = 7'b0000010;
    localparam in_t MATCH = 7'b0000001;

    clock_mode_ctrl #(.RING_SECS(60), .IDLE_SECS(30), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .bt_c(bt_c), .bt_l(bt_l), .bt_r(bt_r), .bt_u(bt_u), .bt_d(bt_d),
        .alarm_match(alarm_match),
        .en_time_hr(en_time_hr), .en_time_min(en_time_min),
        .en_alarm_hr(en_alarm_hr), .en_alarm_min(en_alarm_min),
        .load_time(load_time), .clk_run(clk_run), .disp_alarm(disp_alarm),
        .blank(blank), .alarm_armed(alarm_armed), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic add(input in_t i, input logic [3:0] en, input logic load, run, disp,
                       armed, buzz, input string name);
        vec_t v;
        v.i = i; v.en = en; v.load = load; v.run = run; v.disp = disp;
        v.armed = armed; v.buzz = buzz; v.name = name;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue the expected outputs, compare after the edge.
    task automatic step(input logic rst, input in_t i, input logic [3:0] en,
                        input logic load, run, disp, armed, buzz, input string name);
        out_t e, a;
        reset = rst; bt_c = i.c; bt_l = i.l; bt_r = i.r; bt_u = i.u; bt_d = i.d;
        tick_1hz = i.tick; alarm_match = i.match;
        if (rst) phase = 1'b0;
        else if (i.tick) phase = ~phase;
        e.en = en; e.load = load; e.run = run; e.disp = disp;
        e.armed = armed; e.buzz = buzz;
        if (!phase)               e.blank = 4'b0000;
        else if (en[3] | en[1])   e.blank = 4'b1100;
        else if (en[2] | en[0])   e.blank = 4'b0011;
        else                      e.blank = 4'b0000;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0; bt_c = 1'b0; bt_l = 1'b0; bt_r = 1'b0; bt_u = 1'b0; bt_d = 1'b0;
        tick_1hz = 1'b0; alarm_match = 1'b0;
        a = {en_time_hr, en_time_min, en_alarm_hr, en_alarm_min, load_time, clk_run,
             disp_alarm, blank, alarm_armed, buzzer};
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b (en,load,run,disp,blank,armed,buzz)",
                     name, a, e);
        end
    endtask

    task automatic do_reset();
        for (int n = 0; n < 3; n++)
            step(1'b1, NONE, 4'b0000, 0, 1, 0, 0, 0, $sformatf("reset%0d", n));
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; alarm_match = 1'b0;
        bt_c = 1'b0; bt_l = 1'b0; bt_r = 1'b0; bt_u = 1'b0; bt_d = 1'b0;

        //   inputs c l r u d t m      en     ld run dsp arm bz
        add(7'b0000000, 4'b0000, 0, 1, 0, 0, 0, "clock_idle");
        add(7'b1000000, 4'b0100, 0, 0, 0, 0, 0, "enter_set_time");
        add(7'b0100000, 4'b1000, 0, 0, 0, 0, 0, "time_field_hour");
        add(7'b1000000, 4'b0001, 1, 1, 1, 0, 0, "commit_load");
        add(7'b0000000, 4'b0001, 0, 1, 1, 0, 0, "load_one_cycle");
        add(7'b0100000, 4'b0010, 0, 1, 1, 0, 0, "alarm_field_hour");
        add(7'b0000010, 4'b0010, 0, 1, 1, 0, 0, "blink_on");
        add(7'b0000010, 4'b0010, 0, 1, 1, 0, 0, "blink_off");
        add(7'b0010000, 4'b0001, 0, 1, 1, 0, 0, "alarm_field_min");
        add(7'b1000000, 4'b0000, 0, 1, 0, 0, 0, "exit_to_clock");
        add(7'b0001000, 4'b0000, 0, 1, 0, 1, 0, "arm_up");
        add(7'b0000100, 4'b0000, 0, 1, 0, 0, 0, "disarm_down");
        add(7'b0101000, 4'b0000, 0, 1, 0, 0, 0, "l_masks_u");
        add(7'b1100000, 4'b0100, 0, 0, 0, 0, 0, "c_beats_l_clock");
        add(7'b1100000, 4'b0001, 1, 1, 1, 0, 0, "c_beats_l_set_time");
        add(7'b1000000, 4'b0000, 0, 1, 0, 0, 0, "exit_alarm");
        add(7'b0001000, 4'b0000, 0, 1, 0, 1, 0, "arm");
        add(7'b0000101, 4'b0000, 0, 1, 0, 1, 1, "match_beats_down");
        add(7'b1000001, 4'b0000, 0, 1, 0, 1, 0, "c_stops_ring");
        add(7'b0000001, 4'b0000, 0, 1, 0, 1, 0, "no_retrigger");
        add(7'b0000000, 4'b0000, 0, 1, 0, 1, 0, "match_low");
        add(7'b0000001, 4'b0000, 0, 1, 0, 1, 1, "retrigger");
        add(7'b0100000, 4'b0000, 0, 1, 0, 1, 0, "l_stops_ring");
        add(7'b0000010, 4'b0000, 0, 1, 0, 1, 0, "clock_tick_no_blank");
        add(7'b1000001, 4'b0100, 0, 0, 0, 1, 0, "c_beats_match");

        do_reset();
        foreach (tbl[k])
            step(1'b0, tbl[k].i, tbl[k].en, tbl[k].load, tbl[k].run, tbl[k].disp,
                 tbl[k].armed, tbl[k].buzz, tbl[k].name);

        // idle timeout in SET_TIME: 30th tick returns to CLOCK without load
        do_reset();
        step(1'b0, C, 4'b0100, 0, 0, 0, 0, 0, "idle_enter");
        for (int k = 1; k <= 30; k++)
            step(1'b0, TICK, (k < 30) ? 4'b0100 : 4'b0000, 0, (k < 30) ? 1'b0 : 1'b1, 0, 0, 0,
                 $sformatf("idle_time_tick%0d", k));

        // idle timeout in SET_ALARM, restarted by a button press
        step(1'b0, C, 4'b0100, 0, 0, 0, 0, 0, "idle2_enter");
        step(1'b0, C, 4'b0001, 1, 1, 1, 0, 0, "idle2_alarm");
        for (int k = 1; k <= 20; k++)
            step(1'b0, TICK, 4'b0001, 0, 1, 1, 0, 0, $sformatf("idle2_pre%0d", k));
        step(1'b0, R, 4'b0001, 0, 1, 1, 0, 0, "idle2_restart");
        for (int k = 1; k <= 30; k++)
            step(1'b0, TICK, (k < 30) ? 4'b0001 : 4'b0000, 0, 1, (k < 30) ? 1'b1 : 1'b0, 0, 0,
                 $sformatf("idle2_tick%0d", k));

        // ring timeout, no re-trigger while match held, re-arm after match drops
        do_reset();
        step(1'b0, U, 4'b0000, 0, 1, 0, 1, 0, "ring_arm");
        step(1'b0, MATCH, 4'b0000, 0, 1, 0, 1, 1, "ring_start");
        for (int k = 1; k <= 60; k++)
            step(1'b0, TICK | MATCH, 4'b0000, 0, 1, 0, 1, (k < 60) ? 1'b1 : 1'b0,
                 $sformatf("ring_tick%0d", k));
        for (int k = 0; k < 3; k++)
            step(1'b0, MATCH, 4'b0000, 0, 1, 0, 1, 0, $sformatf("ring_hold%0d", k));
        step(1'b0, NONE, 4'b0000, 0, 1, 0, 1, 0, "ring_drop");
        step(1'b0, MATCH, 4'b0000, 0, 1, 0, 1, 1, "ring_rearm");
        step(1'b1, MATCH, 4'b0000, 0, 1, 0, 0, 0, "ring_reset");

        // SET_ALARM hour blink over 4 ticks, then reset with bt_c held
        step(1'b0, C, 4'b0100, 0, 0, 0, 0, 0, "blink_enter");
        step(1'b0, C, 4'b0001, 1, 1, 1, 0, 0, "blink_alarm");
        step(1'b0, L, 4'b0010, 0, 1, 1, 0, 0, "blink_hour");
        for (int k = 1; k <= 4; k++)
            step(1'b0, TICK, 4'b0010, 0, 1, 1, 0, 0, $sformatf("blink_tick%0d", k));
        step(1'b0, TICK, 4'b0010, 0, 1, 1, 0, 0, "blink_tick5");
        step(1'b1, C, 4'b0000, 0, 1, 0, 0, 0, "blink_reset");
        step(1'b0, C, 4'b0100, 0, 0, 0, 0, 0, "settime_again");
        step(1'b1, C, 4'b0000, 0, 1, 0, 0, 0, "reset_no_load");
        step(1'b0, NONE, 4'b0000, 0, 1, 0, 0, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
